// File: rtl/count_defs_pkg.sv
// rtl/count_defs_pkg.sv - shared direction/mode types and widths for the mod-N counter
package count_defs_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP   = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  localparam int WRAP_CNT_W = 16;

endpackage

// File: rtl/modn_next_calc.sv
// rtl/modn_next_calc.sv - combinational next-count, terminal and wrap computation
module modn_next_calc
  import count_defs_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] s,
  input  logic             up_down,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             tc_n,
  output logic             wrap_n
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] sum;
  dir_e           dir;
  mode_e          mode;

  always_comb begin
    cur_x  = {1'b0, cur};
    s_x    = {1'b0, s};
    sum    = cur_x + s_x;
    dir    = dir_e'(up_down);
    mode   = mode_e'(sat);
    next   = cur;
    wrap_n = 1'b0;
    if (s != '0) begin
      if (dir == DIR_UP) begin
        if (sum < MOD_X) begin
          next = WIDTH'(sum);
        end else if (mode == MODE_WRAP) begin
          next   = WIDTH'(sum - MOD_X);
          wrap_n = 1'b1;
        end else begin
          next = MAX_V;
        end
      end else begin
        if (s_x <= cur_x) begin
          next = WIDTH'(cur_x - s_x);
        end else if (mode == MODE_WRAP) begin
          // cur + MODULUS cannot exceed WIDTH+1 bits since MODULUS <= 2**WIDTH
          next   = WIDTH'(cur_x + MOD_X - s_x);
          wrap_n = 1'b1;
        end else begin
          next = '0;
        end
      end
    end
    tc_n = (s != '0) && ((dir == DIR_UP) ? (next == MAX_V) : (next == '0));
  end

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - mod-N loadable up/down counter; COUNTER_WRAP_CNT_EN adds wrap_count
module modn_updown_counter
  import count_defs_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  tc,
  output logic                  wrap
`ifdef COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS out of range 2..2**WIDTH");
  end

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] calc_next;
  logic             calc_tc;
  logic             calc_wrap;

  assign s_eff    = (step > MAX_V) ? MAX_V : step;
  assign load_val = ({1'b0, data_in} < MOD_X) ? data_in : MAX_V;

  modn_next_calc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_calc (
    .cur     (data_out),
    .s       (s_eff),
    .up_down (up_down),
    .sat     (sat),
    .next    (calc_next),
    .tc_n    (calc_tc),
    .wrap_n  (calc_wrap)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      data_out <= '0;
      tc       <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      data_out <= load_val;
      tc       <= 1'b0;
      wrap     <= 1'b0;
    end else if (enable) begin
      data_out <= calc_next;
      tc       <= calc_tc;
      wrap     <= calc_wrap;
    end else begin
      tc       <= 1'b0;
      wrap     <= 1'b0;
    end
  end

`ifdef COUNTER_WRAP_CNT_EN
  // Counts on the same edge that sets the wrap pulse
  always_ff @(posedge clock) begin
    if (!resetn || load) begin
      wrap_count <= '0;
    end else if (enable && calc_wrap && (wrap_count != '1)) begin
      wrap_count <= wrap_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - directed-vector bench for modn_updown_counter
module tb_modn_updown_counter;
  import count_defs_pkg::*;

  logic       clock = 1'b0;
  logic       resetn, load, enable, up_down, sat;
  logic [3:0] step, data_in;
  logic [3:0] data_out;
  logic       tc, wrap;
`ifdef COUNTER_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  modn_updown_counter #(.WIDTH(4), .MODULUS(12)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .load     (load),
    .enable   (enable),
    .up_down  (up_down),
    .sat      (sat),
    .step     (step),
    .data_in  (data_in),
    .data_out (data_out),
    .tc       (tc),
    .wrap     (wrap)
`ifdef COUNTER_WRAP_CNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply(input logic rn, input logic ld, input logic en, input logic ud,
                       input logic st, input logic [3:0] stp, input logic [3:0] din);
    resetn = rn; load = ld; enable = en; up_down = ud; sat = st; step = stp; data_in = din;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input int d, input int t, input int w);
    check({tag, ".data_out"}, 32'(data_out), d);
    check({tag, ".tc"},       32'(tc),       t);
    check({tag, ".wrap"},     32'(wrap),     w);
  endtask

  initial begin
    resetn = 1'b0; load = 1'b0; enable = 1'b0; up_down = 1'b1; sat = 1'b0;
    step = '0; data_in = '0;
    apply(0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 0);
    expect_out("reset", 0, 0, 0);

    // reset overrides load and enable mid-count
    apply(1, 1, 0, 1, 0, 0, 7);
    expect_out("load7", 7, 0, 0);
    apply(0, 1, 1, 1, 0, 3, 3);
    expect_out("rst_over", 0, 0, 0);

    // load clamp and plain load
    apply(1, 1, 0, 1, 0, 0, 14);
    expect_out("clamp14", 11, 0, 0);
    apply(1, 1, 0, 1, 0, 0, 12);
    expect_out("clamp12", 11, 0, 0);
    apply(1, 1, 0, 1, 0, 0, 5);
    expect_out("load5", 5, 0, 0);

    // up wrap: 8 -> 11 (tc) -> 2 (wrap)
    apply(1, 1, 0, 1, 0, 0, 8);
    apply(1, 0, 1, 1, 0, 3, 0);
    expect_out("up_tc", 11, 1, 0);
    apply(1, 0, 1, 1, 0, 3, 0);
    expect_out("up_wrap", 2, 0, 1);

    // up saturate, then saturate again at top
    apply(1, 1, 0, 1, 1, 0, 10);
    apply(1, 0, 1, 1, 1, 3, 0);
    expect_out("up_sat", 11, 1, 0);
    apply(1, 0, 1, 1, 1, 3, 0);
    expect_out("up_sat2", 11, 1, 0);

    // down saturate 2 -> 0
    apply(1, 1, 0, 1, 0, 0, 2);
    apply(1, 0, 1, 0, 1, 4, 0);
    expect_out("dn_sat", 0, 1, 0);

    // down wrap 0 -> 11, then step 0 holds
    apply(1, 1, 0, 1, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 1, 0);
    expect_out("dn_wrap", 11, 0, 1);
    apply(1, 0, 1, 0, 0, 0, 0);
    expect_out("step0", 11, 0, 0);

    // oversized step clamps to 11: 1 + 11 = 12 -> 0
    apply(1, 1, 0, 1, 0, 0, 1);
    apply(1, 0, 1, 1, 0, 13, 0);
    expect_out("step13", 0, 0, 1);
`ifdef COUNTER_WRAP_CNT_EN
    check("wrap_count1", 32'(wrap_count), 1);
`endif
    apply(1, 1, 1, 1, 0, 3, 4);
    expect_out("load_wins", 4, 0, 0);
`ifdef COUNTER_WRAP_CNT_EN
    check("wrap_count0", 32'(wrap_count), 0);
`endif

    // down wrap 4 - 5 -> 11 then hold drops the pulse
    apply(1, 0, 1, 0, 0, 5, 0);
    expect_out("dn_wrap5", 11, 0, 1);
    apply(1, 0, 0, 0, 0, 5, 0);
    expect_out("hold", 11, 0, 0);

    // plain down count landing on 0
    apply(1, 1, 0, 0, 0, 0, 3);
    apply(1, 0, 1, 0, 0, 3, 0);
    expect_out("dn_zero", 0, 1, 0);
    apply(1, 0, 1, 1, 0, 2, 0);
    expect_out("up_mid", 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised successor to the fixed-width loadable up/down counter.
- Configurable width and modulus; per-cycle programmable step; run-time wrap or saturate mode; registered terminal-count and wrap pulses.
- Serves as the DUT for the counter testbench environment (generator, driver, read/write monitors, reference model, scoreboard).

Parameters:
- WIDTH, 4, counter/data width in bits.
- MODULUS, 12, count range 0..MODULUS-1; legal range 2..2**WIDTH; elaboration-time $error outside this range.

Ports:
- clock  in  1  single clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- load  in  1  load data_in this cycle.
- enable  in  1  count this cycle.
- up_down  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at range ends, 0 = wrap modulo MODULUS.
- step  in  WIDTH  increment/decrement magnitude.
- data_in  in  WIDTH  load value.
- data_out  out  WIDTH  registered count.
- tc  out  1  registered pulse: terminal value reached by a count update.
- wrap  out  1  registered pulse: count wrapped past a range end.

Behaviour:
- Priority per edge: reset > load > enable > hold.
- Reset (resetn=0 at edge): data_out=0, tc=0, wrap=0. Overrides load/enable; a mid-count reset discards the in-flight update.
- Load (enable ignored): data_out=data_in if data_in<MODULUS, else MODULUS-1 (clamp). tc=0, wrap=0.
- Count (enable=1, load=0):
  - Effective step s=min(step, MODULUS-1).
  - s=0: hold; tc=0, wrap=0.
- Up: sum=data_out+s, evaluated in WIDTH+1 bits.
  - If sum<MODULUS: next=sum.
  - Else, sat=0: next=sum-MODULUS, wrap=1.
  - Else, sat=1: next=MODULUS-1, wrap=0.
- Down:
  - If s<=data_out: next=data_out-s.
  - Else, sat=0: next=data_out+MODULUS-s (WIDTH+1-bit arithmetic), wrap=1.
  - Else, sat=1: next=0, wrap=0.
- tc=1 when a count update (s>0) produces next==MODULUS-1 (up) or next==0 (down), including saturate and wrap landings.
- Hold (enable=0, load=0): data_out unchanged; tc=0, wrap=0.
- Latency: one cycle from sampled inputs to data_out/tc/wrap. tc and wrap are single-cycle pulses, never sticky.
- Direction or mode changes take effect on the same edge they are sampled. No internal state besides data_out and the pulse flops (plus the optional counter).

Optional Feature:
- Macro: COUNTER_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_count (16 bits).
  - Increments on every edge where wrap is set; saturates at 16'hFFFF.
  - Cleared to 0 by reset and by load.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Shared package count_defs_pkg:
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_e.
  - typedef enum logic {MODE_WRAP=0, MODE_SAT=1} mode_e.
  - localparam WRAP_CNT_W=16.
  - Transaction and model classes reuse these types.
- Sub-module modn_next_calc: purely combinational.
  - Inputs: cur, s, up_down, sat.
  - Outputs: next, tc_n, wrap_n.
  - Parametrised by WIDTH and MODULUS.
  - The top module holds the registers and priority logic.

Test Plan (WIDTH=4, MODULUS=12):
- data_out=7, enable=1, load=1, resetn=0 for one edge -> data_out=0, tc=0, wrap=0 next cycle.
- load=1, data_in=14 -> data_out=11. Then load=1, data_in=5, enable=0 -> data_out=5. tc=wrap=0 throughout.
- Up, sat=0, step=3: from 8 -> 11 with tc=1; next edge -> 2 with wrap=1, tc=0.
- Up, sat=1, step=3, from 10 -> 11, tc=1, wrap=0. Down, sat=1, step=4, from 2 -> 0, tc=1.
- Down, sat=0, step=1, from 0 -> 11, wrap=1. Then step=0, enable=1 -> holds 11, tc=wrap=0.
- step=13, up, sat=0, from 1 -> s=11, 12-12=0, wrap=1. load=1 with enable=1 same edge -> load wins. With COUNTER_WRAP_CNT_EN: wrap_count=1, then 0 after the load.
